// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment BCD counter: segment patterns,
// the auto-repeat state type and small helper functions.
package seven_seg_pkg;

    // Lit patterns, bit order {G,F,E,D,C,B,A}, 1 = segment lit.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Per-switch auto-repeat state.
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HELD,
        RPT_REPEAT
    } repeat_state_t;

    // Lit pattern for one BCD digit; non-decimal codes show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Elaboration-time binary to 4-digit BCD conversion (used for MAX_COUNT).
    function automatic logic [15:0] bin_to_bcd(input int value);
        int          v;
        logic [15:0] bcd;
        v   = value;
        bcd = '0;
        for (int i = 0; i < 4; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/seven_seg_step_filter.sv
// Turns one raw, bouncing switch into a clean one-cycle step pulse:
// 2-flop synchroniser, debounce counter, rising-edge detect and, when the
// SEG_AUTO_REPEAT_EN macro is defined, an auto-repeat FSM.
module seven_seg_step_filter
    import seven_seg_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Step
);

    localparam int             DB_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

    logic            r_sync_meta;
    logic            r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_filt;
    logic            r_filt_d;
    logic            w_rise;

    // Synchronise the raw switch, debounce it and keep a delayed copy for edge detect.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_db_cnt    <= '0;
            r_filt      <= 1'b0;
            r_filt_d    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values; blocking here would collapse the synchroniser.
            r_sync_meta <= i_Switch;
            r_sync      <= r_sync_meta;
            r_filt_d    <= r_filt;
            if (r_sync != r_filt) begin
                if (r_db_cnt == DB_LAST) begin
                    r_filt   <= r_sync;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_rise = r_filt & ~r_filt_d;

`ifdef SEG_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    repeat_state_t    r_state;
    repeat_state_t    w_state_next;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_next;
    logic             w_step;

    // Repeat FSM state and interval counter.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state   <= RPT_IDLE;
            r_rpt_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rpt_cnt <= w_rpt_cnt_next;
        end
    end

    // Next state and step: one step on press, after the initial delay, then every period.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        w_state_next   = r_state;
        w_rpt_cnt_next = r_rpt_cnt + 1'b1;
        w_step         = 1'b0;
        if (!r_filt) begin
            w_state_next   = RPT_IDLE;
            w_rpt_cnt_next = '0;
        end else begin
            case (r_state)
                RPT_IDLE: begin
                    w_rpt_cnt_next = '0;
                    if (w_rise) begin
                        w_step       = 1'b1;
                        w_state_next = RPT_HELD;
                    end
                end
                RPT_HELD: begin
                    if (r_rpt_cnt == RPT_DELAY_LAST) begin
                        w_step         = 1'b1;
                        w_state_next   = RPT_REPEAT;
                        w_rpt_cnt_next = '0;
                    end
                end
                RPT_REPEAT: begin
                    if (r_rpt_cnt == RPT_PERIOD_LAST) begin
                        w_step         = 1'b1;
                        w_rpt_cnt_next = '0;
                    end
                end
                default: begin
                    w_state_next   = RPT_IDLE;
                    w_rpt_cnt_next = '0;
                end
            endcase
        end
    end

    assign o_Step = w_step;
`else
    // One step per filtered press.
    assign o_Step = w_rise;
`endif

endmodule

// File: rtl/seven_seg_bcd_counter.sv
// Debounced up/down BCD counter with registered seven-segment outputs.
// Optional auto-repeat on held switches: define SEG_AUTO_REPEAT_EN.
module seven_seg_bcd_counter
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int MAX_COUNT      = 99,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Switch_Up,
    input  logic                    i_Switch_Down,
    input  logic                    i_Clear,
    output logic [4*NUM_DIGITS-1:0] o_Count_BCD,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic                    o_Wrap
);

    localparam int              CW           = 4 * NUM_DIGITS;
    localparam int              SW           = 7 * NUM_DIGITS;
    localparam logic [15:0]     MAX_BCD_FULL = bin_to_bcd(MAX_COUNT);
    localparam logic [CW-1:0]   MAX_BCD      = MAX_BCD_FULL[CW-1:0];
    localparam logic [6:0]      SEG_POL      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [SW-1:0]   SEG_RST      = {NUM_DIGITS{SEG_0 ^ SEG_POL}};

    logic          w_up;
    logic          w_down;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_inc;
    logic [CW-1:0] w_count_dec;
    logic          w_carry;
    logic          w_borrow;
    logic          r_wrap;
    logic [SW-1:0] r_seg;
    logic [SW-1:0] w_seg_next;

    seven_seg_step_filter #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_filter_up (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch_Up),
        .o_Step   (w_up)
    );

    seven_seg_step_filter #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_filter_down (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch_Down),
        .o_Step   (w_down)
    );

    // BCD increment and decrement, carry/borrow rippling digit by digit.
    always_comb begin
        w_count_inc = r_count;
        w_count_dec = r_count;
        w_carry     = 1'b1;
        w_borrow    = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_carry) begin
                if (r_count[4*d +: 4] == 4'd9) begin
                    w_count_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*d +: 4] == 4'd0) begin
                    w_count_dec[4*d +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                    w_borrow              = 1'b0;
                end
            end
        end
    end

    // Count register and wrap pulse; clear wins, opposing steps cancel.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_Clear) begin
                r_count <= '0;
            end else if (w_up && !w_down) begin
                if (r_count == MAX_BCD) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= w_count_inc;
                end
            end else if (w_down && !w_up) begin
                if (r_count == '0) begin
                    r_count <= MAX_BCD;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= w_count_dec;
                end
            end
        end
    end

    // Segment patterns for the current count, with output polarity applied.
    always_comb begin
        w_seg_next = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_seg_next[7*d +: 7] = seg_decode(r_count[4*d +: 4]) ^ SEG_POL;
        end
    end

    // Segment register, one cycle behind the count.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_seg <= SEG_RST;
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign o_Count_BCD = r_count;
    assign o_Segments  = r_seg;
    assign o_Wrap      = r_wrap;

endmodule

// File: tb/tb_seven_seg_bcd_counter.sv
// Directed testbench for seven_seg_bcd_counter (2 digits, short debounce).
// Expectations for the held-switch test depend on SEG_AUTO_REPEAT_EN.
module tb_seven_seg_bcd_counter;

`ifdef SEG_AUTO_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    // Active-low segment patterns used by the checks.
    localparam logic [6:0] L0_N = ~7'h3F;
    localparam logic [6:0] L2_N = ~7'h5B;
    localparam logic [6:0] L3_N = ~7'h4F;
    localparam logic [6:0] L4_N = ~7'h66;
    localparam logic [13:0] SEG_00_N = {L0_N, L0_N};

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sw_up  = 1'b0;
    logic        sw_dn  = 1'b0;
    logic        clr    = 1'b0;
    logic [7:0]  count_bcd;
    logic [13:0] segs;
    logic        wrap;

    int n_checks  = 0;
    int n_errors  = 0;
    int wrap_seen = 0;

    seven_seg_bcd_counter #(
        .NUM_DIGITS     (2),
        .MAX_COUNT      (99),
        .DEBOUNCE_LIMIT (4),
        .SEG_ACTIVE_LOW (1),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Switch_Up   (sw_up),
        .i_Switch_Down (sw_dn),
        .i_Clear       (clr),
        .o_Count_BCD   (count_bcd),
        .o_Segments    (segs),
        .o_Wrap        (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wrap) wrap_seen++;
    endtask

    // One clean press and release of the selected switch(es).
    task automatic press(input logic up, input logic dn);
        sw_up = up;
        sw_dn = dn;
        repeat (12) tick();
        sw_up = 1'b0;
        sw_dn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        int   nz;
        logic found;

        // Reset values.
        repeat (2) tick();
        check("rst_count", count_bcd, 8'h00);
        check("rst_segs",  segs, SEG_00_N);
        check("rst_wrap",  wrap, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Three clean up presses; segment register lags the count by one cycle.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        sw_up = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (count_bcd != 8'h02) found = 1'b1;
        end
        check("cnt3_seen",  found, 1'b1);
        check("cnt3_lag",   segs[6:0], L2_N);
        tick();
        check("cnt3_count", count_bcd, 8'h03);
        check("cnt3_dig0",  segs[6:0],  L3_N);
        check("cnt3_dig1",  segs[13:7], L0_N);
        sw_up = 1'b0;
        repeat (12) tick();

        // Wrap in both directions.
        do_clear();
        check("clear", count_bcd, 8'h00);
        wrap_seen = 0;
        press(1'b0, 1'b1);
        check("dn_wrap_cnt",   count_bcd, 8'h99);
        check("dn_wrap_pulse", wrap_seen, 1);
        wrap_seen = 0;
        press(1'b1, 1'b0);
        check("up_wrap_cnt",   count_bcd, 8'h00);
        check("up_wrap_pulse", wrap_seen, 1);
        wrap_seen = 0;
        press(1'b0, 1'b1);
        check("dn_wrap2_cnt",   count_bcd, 8'h99);
        check("dn_wrap2_pulse", wrap_seen, 1);

        // Carry and borrow across digits, then build 42.
        do_clear();
        for (int i = 0; i < 40; i++) begin
            press(1'b1, 1'b0);
            if (i == 9) check("carry_10", count_bcd, 8'h10);
        end
        check("cnt_40", count_bcd, 8'h40);
        press(1'b0, 1'b1);
        check("borrow_39", count_bcd, 8'h39);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("cnt_42",  count_bcd, 8'h42);
        check("seg_42_0", segs[6:0],  L2_N);
        check("seg_42_1", segs[13:7], L4_N);

        // Simultaneous up and down cancel.
        wrap_seen = 0;
        press(1'b1, 1'b1);
        check("cancel_cnt",  count_bcd, 8'h42);
        check("cancel_wrap", wrap_seen, 0);

        // Clear held across an up press overrides the step.
        wrap_seen = 0;
        clr = 1'b1;
        tick();
        nz = 0;
        sw_up = 1'b1;
        repeat (12) begin
            tick();
            if (count_bcd != 8'h00) nz++;
        end
        sw_up = 1'b0;
        repeat (12) begin
            tick();
            if (count_bcd != 8'h00) nz++;
        end
        clr = 1'b0;
        tick();
        check("clr_override_nz", nz, 0);
        check("clr_override_cnt", count_bcd, 8'h00);
        check("clr_override_wrap", wrap_seen, 0);

        // Bouncing switch: toggles every 2 cycles, then settles high.
        for (int i = 0; i < 15; i++) begin
            sw_up = ~sw_up;
            tick();
            tick();
        end
        check("bounce_quiet", count_bcd, 8'h00);
        sw_up = 1'b1;
        repeat (14) tick();
        check("bounce_one", count_bcd, 8'h01);
        sw_up = 1'b0;
        repeat (14) tick();
        check("bounce_rel", count_bcd, 8'h01);

        // Held switch: auto-repeat steps at 0, 20, 28, 36, 44, 52 when enabled.
        do_clear();
        sw_up = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (count_bcd != 8'h00) found = 1'b1;
        end
        check("hold_first", found, 1'b1);
        repeat (19) tick();
        check("hold_e19", count_bcd, 8'h01);
        tick();
        check("hold_e20", count_bcd, RPT ? 8'h02 : 8'h01);
        repeat (31) tick();
        check("hold_e51", count_bcd, RPT ? 8'h05 : 8'h01);
        tick();
        check("hold_e52", count_bcd, RPT ? 8'h06 : 8'h01);
        sw_up = 1'b0;
        repeat (16) tick();

        // Asynchronous reset between edges at count 57.
        do_clear();
        for (int i = 0; i < 57; i++) press(1'b1, 1'b0);
        check("cnt_57", count_bcd, 8'h57);
        wrap_seen = 0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt",  count_bcd, 8'h00);
        check("async_rst_segs", segs, SEG_00_N);
        check("async_rst_wrap", wrap, 1'b0);
        repeat (3) tick();

        // Switch held through reset release gives exactly one step.
        sw_up = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (14) tick();
        check("held_rst_step", count_bcd, 8'h01);
        sw_up = 1'b0;
        repeat (14) tick();
        check("held_rst_once", count_bcd, 8'h01);
        check("rst_no_wrap", wrap_seen, 0);

        // Reset mid-debounce abandons the press.
        do_clear();
        sw_up = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #2;
        sw_up = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (14) tick();
        check("mid_db_rst", count_bcd, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
